crack_ctrl: RTL and testbench
=============================

Name: crack_ctrl

Overview:
- Search sequencer that sits directly downstream of the ASCII decimal candidate generator.
- Takes the generator's 8-character ASCII candidate and hands it to a hash engine over a valid/ready handshake.
- Compares the returned 128-bit digest with the target digest.
- Pulses the generator's next input to advance, and stops on a match or when candidate "99999999" has been checked.

Parameters:
- DIGEST_W, 128, width of the hash digest and of the target digest.
- CAND_W, 64, candidate width: 8 ASCII bytes, most-significant character in bits [63:56].
- CNT_W, 32, width of the tried-candidate counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset.
- start  input  1  one-cycle pulse; begins a search. Honoured only in IDLE.
- target_hash  input  DIGEST_W  digest to match. Sampled on an accepted start.
- cand_in  input  CAND_W  current candidate from the generator's value output.
- cand_next  output  1  one-cycle pulse to the generator's next input.
- hash_valid  output  1  candidate offered to the hash engine.
- hash_ready  input  1  hash engine accepts the offered candidate.
- hash_msg  output  CAND_W  candidate sent to the hash engine.
- digest_valid  input  1  one-cycle pulse; digest is valid.
- digest  input  DIGEST_W  hash engine result.
- busy  output  1  high in every state except IDLE.
- done  output  1  sticky; search finished.
- found  output  1  sticky; the search ended on a match.
- result  output  CAND_W  the matching candidate, valid when found=1.
- tried_count  output  CNT_W  number of candidates compared.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Values while reset is high (and after it):
  - state=IDLE
  - cand_next=0, hash_valid=0, hash_msg=0, busy=0, done=0, found=0
  - result=0, tried_count=0
  - internal target register and current-candidate register = 0
- Reset mid-search aborts immediately; any in-flight digest is discarded. This block does not reset the generator.
- FSM states: IDLE, ISSUE, WAIT, CHECK, ADVANCE, FINISH.
- IDLE:
  - On start=1: latch target_hash; clear done, found and tried_count; go to ISSUE.
  - start in any other state is ignored.
- ISSUE:
  - hash_valid=1 and hash_msg=cand_in.
  - hash_msg must hold stable while hash_valid=1 and hash_ready=0. cand_in does not change here, because cand_next is low.
  - When hash_valid&&hash_ready: copy hash_msg into the current-candidate register, drop hash_valid on the next cycle, go to WAIT.
- WAIT:
  - On digest_valid: compare digest with the latched target; go to CHECK with the comparison result registered.
  - digest_valid in any other state is ignored.
- CHECK (exactly 1 cycle):
  - tried_count increments by 1.
  - Match: result=current candidate, found=1, done=1; go to FINISH.
  - No match and current candidate=="99999999" (every byte 8'h39): found=0, done=1; go to FINISH. cand_next is not pulsed, so the generator does not wrap.
  - Otherwise: cand_next=1 for exactly this cycle; go to ADVANCE.
- ADVANCE (1 cycle): lets the generator's registered value update; then go to ISSUE.
- FINISH (1 cycle): go to IDLE. done, found, result and tried_count hold until the next accepted start or reset.
- Throughput: with hash_ready held high and a digest latency of L cycles after acceptance, each candidate takes L+3 cycles (ISSUE 1, WAIT L, CHECK 1, ADVANCE 1).
- Width rules: the digest comparison is a full DIGEST_W-bit equality. tried_count wraps modulo 2^CNT_W; the maximum count is 10^8, which fits in 32 bits.
- Simultaneous events:
  - start while busy: ignored.
  - digest_valid in the same cycle as hash acceptance: ignored. The digest is counted only in WAIT.
  - reset together with any other input: reset wins.

Test Plan:
- Generator starts at "00000000"; hash-engine model returns digest=H("00000003") after 2 cycles; target=H("00000003"); start pulse -> found=1, done=1, result="00000003", tried_count=4, exactly 3 cand_next pulses, total 4×5 cycles from ISSUE entry.
- Generator starts at "99999997"; target never matches -> candidates "99999997", "99999998", "99999999" are issued; done=1, found=0, tried_count=3; no cand_next after "99999999".
- hash_ready held low 5 cycles in ISSUE -> hash_valid stays 1 and hash_msg stays stable for all 5 cycles; acceptance on cycle 6 only.
- Spurious digest_valid pulses in IDLE and ADVANCE, and a start pulse during WAIT -> no state change, counters unchanged, search completes normally.
- reset asserted while in WAIT -> next cycle busy=0, done=0, found=0, tried_count=0; a later digest_valid is ignored; a new start begins cleanly.
- Match on the very first candidate "12345678" -> tried_count=1, zero cand_next pulses, result="12345678".

Source files
------------

// File: rtl/crack_ctrl.sv
// -----------------------------------------------------------------------------
// crack_ctrl
// Search sequencer placed between an ASCII decimal candidate generator and a
// hash engine. It offers each candidate to the engine over valid/ready, waits
// for the digest, compares it with the latched target and either stops (match,
// or the last candidate "99999999" was checked) or pulses the generator to
// advance.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        one-cycle pulse, begins a search (honoured only when idle)
//   target_hash  digest to search for, sampled on an accepted start
//   cand_in      current candidate from the generator
//   cand_next    one-cycle pulse asking the generator for the next candidate
//   hash_valid   candidate offered to the hash engine
//   hash_ready   hash engine accepts the offered candidate
//   hash_msg     candidate sent to the hash engine
//   digest_valid one-cycle pulse, digest is valid
//   digest       hash engine result
//   busy         high whenever a search is in progress
//   done         sticky, search finished
//   found        sticky, search ended on a match
//   result       matching candidate (valid when found=1)
//   tried_count  number of candidates compared
// -----------------------------------------------------------------------------
module crack_ctrl #(
    parameter int DIGEST_W = 128,
    parameter int CAND_W   = 64,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DIGEST_W-1:0] target_hash,
    input  logic [CAND_W-1:0]   cand_in,
    output logic                cand_next,
    output logic                hash_valid,
    input  logic                hash_ready,
    output logic [CAND_W-1:0]   hash_msg,
    input  logic                digest_valid,
    input  logic [DIGEST_W-1:0] digest,
    output logic                busy,
    output logic                done,
    output logic                found,
    output logic [CAND_W-1:0]   result,
    output logic [CNT_W-1:0]    tried_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CHECK   = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

    // True when every character of the candidate is ASCII '9'.
    function automatic logic is_last_cand(input logic [CAND_W-1:0] cand);
        logic all_nines;
        all_nines = 1'b1;
        for (int i = 0; i < CAND_W / 8; i++) begin
            all_nines = all_nines & (cand[i*8 +: 8] == 8'h39);
        end
        return all_nines;
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic [DIGEST_W-1:0] target_r;
    logic [CAND_W-1:0]   cur_cand_r;
    logic                match_r;
    logic                digest_match_s;
    logic                last_cand_s;

    logic                cand_next_r;
    logic                hash_valid_r;
    logic [CAND_W-1:0]   hash_msg_r;
    logic                busy_r;
    logic                done_r;
    logic                found_r;
    logic [CAND_W-1:0]   result_r;
    logic [CNT_W-1:0]    tried_count_r;

    // Next-state decode and digest/candidate comparisons.
    always_comb begin
        state_next_s   = state_r;
        digest_match_s = (digest == target_r);
        last_cand_s    = is_last_cand(cur_cand_r);
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_ISSUE;
                else       state_next_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (hash_valid_r && hash_ready) state_next_s = ST_WAIT;
                else                            state_next_s = ST_ISSUE;
            end
            ST_WAIT: begin
                if (digest_valid) state_next_s = ST_CHECK;
                else              state_next_s = ST_WAIT;
            end
            ST_CHECK: begin
                if (match_r || last_cand_s) state_next_s = ST_FINISH;
                else                        state_next_s = ST_ADVANCE;
            end
            ST_ADVANCE: state_next_s = ST_ISSUE;
            ST_FINISH:  state_next_s = ST_IDLE;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // State register, registered outputs and search bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            target_r      <= {DIGEST_W{1'b0}};
            cur_cand_r    <= {CAND_W{1'b0}};
            match_r       <= 1'b0;
            cand_next_r   <= 1'b0;
            hash_valid_r  <= 1'b0;
            hash_msg_r    <= {CAND_W{1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            found_r       <= 1'b0;
            result_r      <= {CAND_W{1'b0}};
            tried_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_next_s;
            busy_r       <= (state_next_s != ST_IDLE);
            hash_valid_r <= (state_next_s == ST_ISSUE);
            // The advance pulse must be high during CHECK, so it is decided
            // one cycle early, when the digest arrives in WAIT.
            cand_next_r  <= (state_r == ST_WAIT) && digest_valid &&
                            !digest_match_s && !last_cand_s;
            // Capture the candidate once on entry to ISSUE; it then stays
            // stable for as long as the engine stalls.
            if ((state_r != ST_ISSUE) && (state_next_s == ST_ISSUE)) begin
                hash_msg_r <= cand_in;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        target_r      <= target_hash;
                        done_r        <= 1'b0;
                        found_r       <= 1'b0;
                        tried_count_r <= {CNT_W{1'b0}};
                    end
                end
                ST_ISSUE: begin
                    if (hash_valid_r && hash_ready) begin
                        cur_cand_r <= hash_msg_r;
                    end
                end
                ST_WAIT: begin
                    if (digest_valid) begin
                        match_r <= digest_match_s;
                    end
                end
                ST_CHECK: begin
                    tried_count_r <= tried_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (match_r) begin
                        result_r <= cur_cand_r;
                        found_r  <= 1'b1;
                        done_r   <= 1'b1;
                    end else if (last_cand_s) begin
                        found_r  <= 1'b0;
                        done_r   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cand_next   = cand_next_r;
    assign hash_valid  = hash_valid_r;
    assign hash_msg    = hash_msg_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign found       = found_r;
    assign result      = result_r;
    assign tried_count = tried_count_r;

endmodule

// File: tb/tb_crack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_crack_ctrl
// Bench for crack_ctrl with a decimal-counter generator model, a hash engine
// model with programmable latency/back-pressure, randomized stray events and a
// candidate-number level reference model checked on every cycle.
// -----------------------------------------------------------------------------
module tb_crack_ctrl;

    localparam int DW = 128;
    localparam int CW = 64;
    localparam int NW = 32;

    localparam int P_IDLE = 0;
    localparam int P_OFFER = 1;
    localparam int P_WAIT = 2;
    localparam int P_CHECK = 3;
    localparam int P_ADV = 4;
    localparam int P_FIN = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] target_hash;
    logic [CW-1:0] cand_in;
    logic          cand_next;
    logic          hash_valid;
    logic          hash_ready;
    logic [CW-1:0] hash_msg;
    logic          digest_valid;
    logic [DW-1:0] digest;
    logic          busy;
    logic          done;
    logic          found;
    logic [CW-1:0] result;
    logic [NW-1:0] tried_count;

    always #5 clk = ~clk;

    crack_ctrl #(.DIGEST_W(DW), .CAND_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .reset(reset), .start(start), .target_hash(target_hash),
        .cand_in(cand_in), .cand_next(cand_next), .hash_valid(hash_valid),
        .hash_ready(hash_ready), .hash_msg(hash_msg), .digest_valid(digest_valid),
        .digest(digest), .busy(busy), .done(done), .found(found),
        .result(result), .tried_count(tried_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] to_ascii(input int unsigned n);
        logic [63:0] r;
        int unsigned v;
        v = n;
        for (int i = 0; i < 8; i++) begin
            r[i*8 +: 8] = 8'h30 + 8'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [127:0] hfun(input logic [63:0] m);
        return {m ^ 64'h5A5A_5A5A_C3C3_C3C3, {m[31:0], m[63:32]} + 64'h0123_4567_89AB_CDEF};
    endfunction

    // ---------------- environment state ----------------
    int unsigned gen_n = 0;
    int          lat = 2;
    int          pend_cnt = 0;
    logic [127:0] pend_dig = 128'd0;
    logic [127:0] cur_tgt = 128'd0;
    bit          spur_en = 1'b0;
    bit          stray_en = 1'b0;
    bit          rand_ready = 1'b0;
    int          ready_low_cnt = 0;
    int          n_pulses = 0;
    int          n_busy = 0;
    int          n_stall = 0;
    bit          cmp_en = 1'b0;
    logic        s_busy, s_done, s_found;
    logic [31:0] s_tried;
    logic [63:0] s_result, s_msg;

    // ---------------- reference model ----------------
    int          ph = P_IDLE;
    logic        hit = 1'b0;
    logic [63:0] m_cur = 64'd0;
    logic [63:0] m_msg = 64'd0;
    logic [63:0] m_res = 64'd0;
    logic [127:0] m_tgt = 128'd0;
    logic [31:0] m_tried = 32'd0;
    bit          m_done = 1'b0;
    bit          m_found = 1'b0;
    logic [63:0] last_c = 64'h3939_3939_3939_3939;

    always @(posedge clk) begin
        if (reset) begin
            ph = P_IDLE; hit = 1'b0; m_cur = 64'd0; m_msg = 64'd0; m_res = 64'd0;
            m_tgt = 128'd0; m_tried = 32'd0; m_done = 1'b0; m_found = 1'b0;
        end else begin
            case (ph)
                P_IDLE: if (start) begin
                    m_tgt = target_hash; m_done = 1'b0; m_found = 1'b0;
                    m_tried = 32'd0; m_msg = cand_in; ph = P_OFFER;
                end
                P_OFFER: if (hash_ready) begin m_cur = m_msg; ph = P_WAIT; end
                P_WAIT: if (digest_valid) begin hit = (digest == m_tgt); ph = P_CHECK; end
                P_CHECK: begin
                    m_tried = m_tried + 32'd1;
                    if (hit) begin m_res = m_cur; m_found = 1'b1; m_done = 1'b1; ph = P_FIN; end
                    else if (m_cur == last_c) begin m_done = 1'b1; ph = P_FIN; end
                    else ph = P_ADV;
                end
                P_ADV: begin m_msg = cand_in; ph = P_OFFER; end
                default: ph = P_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 128'(busy), 128'(ph != P_IDLE));
            chk("hash_valid", 128'(hash_valid), 128'(ph == P_OFFER));
            chk("cand_next", 128'(cand_next),
                128'((ph == P_CHECK) && !hit && (m_cur != last_c)));
            chk("done", 128'(done), 128'(m_done));
            chk("found", 128'(found), 128'(m_found));
            chk("tried_count", 128'(tried_count), 128'(m_tried));
            if (ph == P_OFFER) chk("hash_msg", 128'(hash_msg), 128'(m_msg));
            if (m_found) chk("result", 128'(result), 128'(m_res));
        end
    end

    // One clock of environment: generator, hash engine, stray events.
    task automatic step();
        logic acc, nxt;
        logic [63:0] m;
        @(negedge clk);
        acc = hash_valid && hash_ready;
        m = hash_msg;
        nxt = cand_next;
        if (nxt === 1'b1) n_pulses++;
        if (busy === 1'b1) n_busy++;
        if (hash_valid === 1'b1 && hash_ready === 1'b0) n_stall++;
        s_busy = busy; s_done = done; s_found = found;
        s_tried = tried_count; s_result = result; s_msg = hash_msg;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (nxt === 1'b1) begin
            gen_n = (gen_n + 1) % 100000000;
            cand_in = to_ascii(gen_n);
        end
        digest_valid = 1'b0;
        digest = {$urandom, $urandom, $urandom, $urandom};
        if (acc === 1'b1) begin pend_cnt = lat; pend_dig = hfun(m); end
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin digest_valid = 1'b1; digest = pend_dig; end
        end else if (spur_en && $urandom_range(0, 3) == 0) begin
            digest_valid = 1'b1;
            digest = cur_tgt;
        end
        if (ready_low_cnt > 0) begin
            hash_ready = 1'b0;
            ready_low_cnt--;
        end else begin
            hash_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (stray_en && ph != P_IDLE && $urandom_range(0, 7) == 0) begin
            start = 1'b1;
            target_hash = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic run_search(input int unsigned g0, input logic [127:0] tgt,
                              input int l, input int low);
        bit ok;
        gen_n = g0;
        cand_in = to_ascii(g0);
        lat = l;
        cur_tgt = tgt;
        start = 1'b1;
        target_hash = tgt;
        if (low > 0) begin hash_ready = 1'b0; ready_low_cnt = low; end
        n_pulses = 0; n_busy = 0; n_stall = 0;
        ok = 1'b0;
        step();
        for (int i = 0; i < 3000; i++) begin
            step();
            if (s_done === 1'b1 && s_busy === 1'b0) begin ok = 1'b1; break; end
        end
        chk("search_completes", 128'(ok), 128'(1'b1));
    endtask

    initial begin
        int unsigned g0, off, exp_t;
        bit nomatch, okw;
        logic [127:0] tgt;

        reset = 1'b1; start = 1'b0; target_hash = 128'd0; hash_ready = 1'b1;
        digest_valid = 1'b0; digest = 128'd0; cand_in = to_ascii(0);
        step();
        cmp_en = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_busy", 128'(s_busy), 128'(1'b0));
        chk("rst_done", 128'(s_done), 128'(1'b0));
        chk("rst_found", 128'(s_found), 128'(1'b0));
        chk("rst_tried", 128'(s_tried), 128'(32'd0));
        chk("rst_msg", 128'(s_msg), 128'(64'd0));

        // "00000000" .. match on "00000003", latency 2
        run_search(0, hfun(to_ascii(3)), 2, 0);
        chk("t1_found", 128'(s_found), 128'(1'b1));
        chk("t1_result", 128'(s_result), 128'(64'h3030_3030_3030_3033));
        chk("t1_tried", 128'(s_tried), 128'(32'd4));
        chk("t1_pulses", 128'(n_pulses), 128'(3));
        chk("t1_cycles", 128'(n_busy), 128'(20));

        // end of space: "99999997".."99999999", no match, no wrap
        run_search(99999997, hfun(64'h4142_4344_4546_4748), 3, 0);
        chk("t2_found", 128'(s_found), 128'(1'b0));
        chk("t2_done", 128'(s_done), 128'(1'b1));
        chk("t2_tried", 128'(s_tried), 128'(32'd3));
        chk("t2_pulses", 128'(n_pulses), 128'(2));
        chk("t2_nowrap", 128'(gen_n), 128'(99999999));

        // engine back-pressure for 5 cycles
        run_search(50, hfun(to_ascii(50)), 1, 5);
        chk("t3_stall", 128'(n_stall), 128'(5));
        chk("t3_tried", 128'(s_tried), 128'(32'd1));
        chk("t3_found", 128'(s_found), 128'(1'b1));

        // first candidate matches
        run_search(12345678, hfun(to_ascii(12345678)), 2, 0);
        chk("t4_tried", 128'(s_tried), 128'(32'd1));
        chk("t4_pulses", 128'(n_pulses), 128'(0));
        chk("t4_result", 128'(s_result), 128'(64'h3132_3334_3536_3738));

        // reset while waiting for a digest
        gen_n = 200; cand_in = to_ascii(200); lat = 4; cur_tgt = hfun(to_ascii(205));
        start = 1'b1; target_hash = cur_tgt;
        okw = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (ph == P_WAIT) begin okw = 1'b1; break; end
        end
        chk("t5_reach_wait", 128'(okw), 128'(1'b1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("t5_busy", 128'(s_busy), 128'(1'b0));
        chk("t5_done", 128'(s_done), 128'(1'b0));
        chk("t5_found", 128'(s_found), 128'(1'b0));
        chk("t5_tried", 128'(s_tried), 128'(32'd0));
        repeat (6) step();
        chk("t5_stale_ignored", 128'(s_busy), 128'(1'b0));
        run_search(200, hfun(to_ascii(202)), 2, 0);
        chk("t5_after_tried", 128'(s_tried), 128'(32'd3));
        chk("t5_after_result", 128'(s_result), 128'(to_ascii(202)));

        // randomized searches with stray starts, spurious digests, back-pressure
        spur_en = 1'b1; stray_en = 1'b1; rand_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            off = $urandom_range(0, 4);
            exp_t = off + 1;
            if ($urandom_range(0, 3) == 0) begin
                nomatch = 1'b1;
                g0 = 99999999 - off;
                tgt = hfun(64'h5858_5858_5858_5858);
            end else begin
                nomatch = 1'b0;
                g0 = $urandom_range(0, 99999000);
                tgt = hfun(to_ascii(g0 + off));
            end
            run_search(g0, tgt, $urandom_range(1, 4), 0);
            chk("rnd_found", 128'(s_found), 128'(!nomatch));
            chk("rnd_tried", 128'(s_tried), 128'(exp_t));
            if (!nomatch) chk("rnd_result", 128'(s_result), 128'(to_ascii(g0 + off)));
            repeat ($urandom_range(1, 4)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
